// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake between the pipeline and the iterative mul/div sequencer.
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            start_EX;
  logic [1:0]      op_EX;
  logic [XLEN-1:0] operandA_EX;
  logic [XLEN-1:0] operandB_EX;
  logic            flush_EX;
  logic            stall_MD;
  logic [XLEN-1:0] result_EX;
  logic            resultValid_EX;
  logic            busy;

  modport master (
    output start_EX, op_EX, operandA_EX, operandB_EX, flush_EX,
    input  stall_MD, result_EX, resultValid_EX, busy
  );
  modport slave (
    input  start_EX, op_EX, operandA_EX, operandB_EX, flush_EX,
    output stall_MD, result_EX, resultValid_EX, busy
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU: shift-add multiplier and restoring
// divider sharing one {acc, lo} register pair, one iteration per cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  md
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN:0]   acc_q, acc_d;   // mul: high word; div: remainder
  logic [XLEN-1:0] lo_q, lo_d;     // mul: low word; div: quotient
  logic [XLEN-1:0] opnd_q, opnd_d; // mul: multiplicand; div: divisor
  logic [XLEN-1:0] res_q, res_d;

  logic [XLEN:0]   sum, rem_s, trial, acc_it;
  logic [XLEN-1:0] lo_it;

  always_comb begin
    sum   = acc_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_s = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    trial = rem_s - {1'b0, opnd_q};
    if (!op_q[1]) begin
      acc_it = {1'b0, sum[XLEN:1]};
      lo_it  = {sum[0], lo_q[XLEN-1:1]};
    end else if (!trial[XLEN]) begin
      acc_it = trial;
      lo_it  = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      acc_it = rem_s;
      lo_it  = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (md.start_EX && !md.flush_EX) begin
        op_d    = md.op_EX;
        opnd_d  = md.op_EX[1] ? md.operandB_EX : md.operandA_EX;
        lo_d    = md.op_EX[1] ? md.operandA_EX : md.operandB_EX;
        acc_d   = '0;
        cnt_d   = CW'(XLEN);
        state_d = BUSY;
      end
      BUSY: begin
        acc_d = acc_it;
        lo_d  = lo_it;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          // op[0] picks the high word / remainder half
          if (!md.flush_EX) res_d = op_q[0] ? acc_it[XLEN-1:0] : lo_it;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (md.flush_EX) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  // Stall is gated by reset so an aborted op never holds the pipe.
  assign md.stall_MD = rst_n && !md.flush_EX &&
                       (((state_q == IDLE) && md.start_EX) || (state_q == BUSY));
  assign md.resultValid_EX = (state_q == DONE) && !md.flush_EX;
  assign md.result_EX      = res_q;
  assign md.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: mul/div vectors, back-to-back, flush, reset.
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_sequencer_if #(.XLEN(XLEN)) mif ();
  muldiv_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .md(mif.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Starts an op in the next cycle; returns sampled in the DONE cycle with start still high.
  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    @(negedge clk);
    mif.start_EX = 1'b1; mif.op_EX = op; mif.operandA_EX = a; mif.operandB_EX = b;
    #1;
    cyc = 0;
    while (mif.stall_MD && cyc < 100) begin
      cyc++;
      chk({tag, "_novalid"}, mif.resultValid_EX, 1'b0);
      @(negedge clk); #1;
    end
    chk({tag, "_stallcyc"}, cyc, 33);
    chk({tag, "_valid"}, mif.resultValid_EX, 1'b1);
    chk({tag, "_busy"}, mif.busy, 1'b1);
    chk({tag, "_res"}, mif.result_EX, exp);
  endtask

  task automatic go_idle(input string tag, input logic [31:0] exp);
    @(negedge clk);
    mif.start_EX = 1'b0;
    #1;
    chk({tag, "_valid_drop"}, mif.resultValid_EX, 1'b0);
    chk({tag, "_busy_drop"}, mif.busy, 1'b0);
    chk({tag, "_res_hold"}, mif.result_EX, exp);
  endtask

  initial begin
    int seen;
    mif.start_EX = 1'b0; mif.op_EX = 2'b00; mif.flush_EX = 1'b0;
    mif.operandA_EX = '0; mif.operandB_EX = '0;
    #12;
    chk("rst_res", mif.result_EX, 0);
    chk("rst_valid", mif.resultValid_EX, 0);
    chk("rst_busy", mif.busy, 0);
    chk("rst_stall", mif.stall_MD, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op("mul7x6", 2'b00, 32'd7, 32'd6, 32'd42);
    go_idle("mul7x6", 32'd42);
    do_op("mulhu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    go_idle("mulhu_ff", 32'hFFFFFFFE);
    do_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    go_idle("mul_ff", 32'h00000001);

    // back-to-back: second start taken in the IDLE cycle right after DONE
    do_op("divu100_7", 2'b10, 32'd100, 32'd7, 32'd14);
    do_op("remu100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    go_idle("remu100_7", 32'd2);

    do_op("divu_by0", 2'b10, 32'h1234, 32'd0, 32'hFFFFFFFF);
    go_idle("divu_by0", 32'hFFFFFFFF);
    do_op("remu_by0", 2'b11, 32'h1234, 32'd0, 32'h00001234);
    go_idle("remu_by0", 32'h00001234);
    do_op("divu_big", 2'b10, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF);
    go_idle("divu_big", 32'h0000FFFF);

    // flush at BUSY cycle 10
    @(negedge clk);
    mif.start_EX = 1'b1; mif.op_EX = 2'b00; mif.operandA_EX = 32'd9; mif.operandB_EX = 32'd9;
    repeat (10) @(negedge clk);
    mif.flush_EX = 1'b1;
    #1;
    chk("flush_stall", mif.stall_MD, 1'b0);
    chk("flush_valid", mif.resultValid_EX, 1'b0);
    @(negedge clk);
    mif.flush_EX = 1'b0; mif.start_EX = 1'b0;
    #1;
    chk("flush_idle", mif.busy, 1'b0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (mif.resultValid_EX || mif.busy) seen++;
    end
    chk("flush_noresult", seen, 0);
    do_op("mul3x5", 2'b00, 32'd3, 32'd5, 32'd15);
    go_idle("mul3x5", 32'd15);

    // reset at BUSY cycle 5
    @(negedge clk);
    mif.start_EX = 1'b1; mif.op_EX = 2'b01; mif.operandA_EX = 32'hDEAD; mif.operandB_EX = 32'hBEEF;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_res", mif.result_EX, 0);
    chk("rstmid_valid", mif.resultValid_EX, 0);
    chk("rstmid_busy", mif.busy, 0);
    chk("rstmid_stall", mif.stall_MD, 0);
    @(negedge clk);
    mif.start_EX = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstrel_busy", mif.busy, 0);
    chk("rstrel_stall", mif.stall_MD, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (mif.resultValid_EX || mif.busy) seen++;
    end
    chk("rstrel_novalid", seen, 0);
    do_op("mul_post_rst", 2'b00, 32'h10000, 32'h10, 32'h100000);
    go_idle("mul_post_rst", 32'h100000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
